// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter and carry-flag controller for the 9-bit CPU.
// Walks the PC through instruction ROM, redirects it on taken branches
// through a small branch-target LUT, holds the ALU carry flag, and provides
// the start/done handshake to the host.
//
// Build option: define PC_CTRL_FLUSH_EN to insert a one-cycle FLUSH bubble
// after every taken branch. Without it, a taken branch redirects the PC with
// no bubble and fetch_valid stays high.
module pc_ctrl #(
   parameter int PC_W      = 10,
   parameter int LUT_DEPTH = 16,
   localparam int IDX_W    = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             halt,
   input  logic             branch_en,
   input  logic             taken,
   input  logic [IDX_W-1:0] lut_idx,
   input  logic             carry_we,
   input  logic             carry_out,
   input  logic             lut_we,
   input  logic [IDX_W-1:0] lut_waddr,
   input  logic [PC_W-1:0]  lut_wdata,
   output logic [PC_W-1:0]  pc,
   output logic             fetch_valid,
   output logic             carry_q,
   output logic             done
);

`ifdef PC_CTRL_FLUSH_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd3
   } state_t;
`endif

   localparam logic [PC_W-1:0] PC_MAX = {PC_W{1'b1}};

   state_t           state;
   state_t           state_next;
   logic [PC_W-1:0]  pc_next;
   logic [PC_W-1:0]  lut_mem [LUT_DEPTH];
   logic [PC_W-1:0]  lut_rdata;
   logic             branch_hit;
   logic             pc_at_max;
   logic             lut_wr_ok;
   logic             restart;

   assign branch_hit = branch_en & taken;
   assign pc_at_max  = (pc == PC_MAX);
   assign restart    = start & ((state == IDLE) | (state == DONE));
   assign lut_wr_ok  = lut_we & ((state == IDLE) | (state == DONE))
                       & (32'(lut_waddr) < LUT_DEPTH);

   // Branch-target read; an index past the end of a non-power-of-2 table reads as 0
   always_comb begin
      lut_rdata = '0;
      if (32'(lut_idx) < LUT_DEPTH) begin
         lut_rdata = lut_mem[lut_idx];
      end
   end

   // State register: the only place the FSM state changes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and next-PC decision; in RUN the priority is halt, then a
   // taken branch, then the runaway guard at the top of ROM, then PC+1
   always_comb begin
      state_next = state;
      pc_next    = pc;
      case (state)
         IDLE: begin
            pc_next = '0;
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (halt) begin
               state_next = DONE;
            end else if (branch_hit) begin
               pc_next = lut_rdata;
`ifdef PC_CTRL_FLUSH_EN
               state_next = FLUSH;
`else
               state_next = RUN;
`endif
            end else if (pc_at_max) begin
               state_next = DONE;
            end else begin
               pc_next = pc + 1'b1;
            end
         end
`ifdef PC_CTRL_FLUSH_EN
         FLUSH: begin
            state_next = RUN;
         end
`endif
         DONE: begin
            if (start) begin
               state_next = RUN;
               pc_next    = '0;
            end
         end
         default: begin
            state_next = IDLE;
            pc_next    = '0;
         end
      endcase
   end

   // Handshake outputs are decoded from the registered state only, so no
   // input can reach an output combinationally
   always_comb begin
      fetch_valid = 1'b0;
      done        = 1'b0;
      case (state)
         RUN:     fetch_valid = 1'b1;
         DONE:    done        = 1'b1;
         default: begin
            fetch_valid = 1'b0;
            done        = 1'b0;
         end
      endcase
   end

   // Program counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= '0;
      end else begin
         pc <= pc_next;
      end
   end

   // Carry flag: a (re)start clears it, otherwise an executing instruction
   // with carry_we loads the ALU carry, even alongside halt or a taken branch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         carry_q <= 1'b0;
      end else if (restart) begin
         carry_q <= 1'b0;
      end else if (carry_we && fetch_valid) begin
         carry_q <= carry_out;
      end
   end

   // Branch-target table; writes only land while the program is not running,
   // so they can never collide with a branch read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LUT_DEPTH; i++) begin
            lut_mem[i] <= '0;
         end
      end else if (lut_wr_ok) begin
         lut_mem[lut_waddr] <= lut_wdata;
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed self-checking bench for pc_ctrl (default parameters).
// Expected values are written out by hand from the controller's behaviour.
module tb_pc_ctrl;

   localparam int PC_W      = 10;
   localparam int LUT_DEPTH = 16;

   logic            clk;
   logic            reset;
   logic            start;
   logic            halt;
   logic            branch_en;
   logic            taken;
   logic [3:0]      lut_idx;
   logic            carry_we;
   logic            carry_out;
   logic            lut_we;
   logic [3:0]      lut_waddr;
   logic [PC_W-1:0] lut_wdata;
   logic [PC_W-1:0] pc;
   logic            fetch_valid;
   logic            carry_q;
   logic            done;

   int check_count;
   int error_count;

   pc_ctrl #(.PC_W(PC_W), .LUT_DEPTH(LUT_DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .halt        (halt),
      .branch_en   (branch_en),
      .taken       (taken),
      .lut_idx     (lut_idx),
      .carry_we    (carry_we),
      .carry_out   (carry_out),
      .lut_we      (lut_we),
      .lut_waddr   (lut_waddr),
      .lut_wdata   (lut_wdata),
      .pc          (pc),
      .fetch_valid (fetch_valid),
      .carry_q     (carry_q),
      .done        (done)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one cycle of instruction-side inputs, clock it, then clear them
   task automatic applyStimulus(input logic h, input logic b, input logic t,
                                input logic [3:0] idx, input logic cw,
                                input logic co);
      halt      = h;
      branch_en = b;
      taken     = t;
      lut_idx   = idx;
      carry_we  = cw;
      carry_out = co;
      tick();
      halt      = 1'b0;
      branch_en = 1'b0;
      taken     = 1'b0;
      lut_idx   = 4'd0;
      carry_we  = 1'b0;
      carry_out = 1'b0;
   endtask

   task automatic lutWrite(input logic [3:0] addr, input logic [PC_W-1:0] data);
      lut_we    = 1'b1;
      lut_waddr = addr;
      lut_wdata = data;
      tick();
      lut_we    = 1'b0;
      lut_waddr = 4'd0;
      lut_wdata = '0;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // After a taken branch edge: step over the bubble if the flush build is in
   // use (and show that halt is ignored there), then expect the target running
   task automatic expectRedirect(input string tag, input logic [PC_W-1:0] target);
`ifdef PC_CTRL_FLUSH_EN
      checkOutput({tag, "_bubble_fv"}, 32'(fetch_valid), 32'd0);
      checkOutput({tag, "_bubble_pc"}, 32'(pc), 32'(target));
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
`endif
      checkOutput({tag, "_pc"}, 32'(pc), 32'(target));
      checkOutput({tag, "_fv"}, 32'(fetch_valid), 32'd1);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      check_count = 0;
      error_count = 0;
      reset     = 1'b1;
      start     = 1'b0;
      halt      = 1'b0;
      branch_en = 1'b0;
      taken     = 1'b0;
      lut_idx   = 4'd0;
      carry_we  = 1'b0;
      carry_out = 1'b0;
      lut_we    = 1'b0;
      lut_waddr = 4'd0;
      lut_wdata = '0;

      // Reset state
      #12;
      checkOutput("rst_pc", 32'(pc), 32'd0);
      checkOutput("rst_fv", 32'(fetch_valid), 32'd0);
      checkOutput("rst_carry", 32'(carry_q), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      tick();

      // Load the branch table while idle
      lutWrite(4'd3, 10'h120);
      checkOutput("idle_pc", 32'(pc), 32'd0);

      // Sequential run 0..7 with carry traffic, a gated LUT write, halt at 7
      pulseStart();
      checkOutput("start_fv", 32'(fetch_valid), 32'd1);
      for (int i = 0; i < 8; i++) begin
         checkOutput("seq_pc", 32'(pc), 32'(i));
         if (i == 3) checkOutput("carry_set", 32'(carry_q), 32'd1);
         if (i == 6) checkOutput("carry_clr", 32'(carry_q), 32'd0);
         if (i == 5) begin
            lut_we    = 1'b1;
            lut_waddr = 4'd3;
            lut_wdata = 10'h3FF;
         end
         case (i)
            2:       applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            5:       applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            7:       applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            default: applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
         endcase
         lut_we    = 1'b0;
         lut_waddr = 4'd0;
         lut_wdata = '0;
      end
      checkOutput("halt_done", 32'(done), 32'd1);
      checkOutput("halt_pc", 32'(pc), 32'd7);
      checkOutput("halt_fv", 32'(fetch_valid), 32'd0);
      checkOutput("halt_carry", 32'(carry_q), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      checkOutput("done_pc_hold", 32'(pc), 32'd7);
      checkOutput("done_carry_hold", 32'(carry_q), 32'd1);

      // Restart from DONE, start ignored while running, taken branch via idx 3
      pulseStart();
      checkOutput("restart_pc", 32'(pc), 32'd0);
      checkOutput("restart_done", 32'(done), 32'd0);
      checkOutput("restart_carry", 32'(carry_q), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      start = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      start = 1'b0;
      checkOutput("start_ignored_pc", 32'(pc), 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      checkOutput("pre_branch_pc", 32'(pc), 32'd4);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
      expectRedirect("taken", 10'h120);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      checkOutput("taken_halt_done", 32'(done), 32'd1);

      // Not-taken branch, carry written with it, then async reset at pc=5
      pulseStart();
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1);
      checkOutput("not_taken_pc", 32'(pc), 32'd5);
      checkOutput("not_taken_carry", 32'(carry_q), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_pc", 32'(pc), 32'd0);
      checkOutput("async_rst_fv", 32'(fetch_valid), 32'd0);
      checkOutput("async_rst_carry", 32'(carry_q), 32'd0);
      checkOutput("async_rst_done", 32'(done), 32'd0);
      #2;
      reset = 1'b0;
      tick();

      // Reset emptied the table: a branch via idx 3 now lands on 0
      pulseStart();
      checkOutput("post_rst_start_pc", 32'(pc), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
      expectRedirect("cleared_lut", 10'h000);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

      // Runaway guard: table written in DONE, branch to 0x3FE, no halt
      lutWrite(4'd0, 10'h3FE);
      pulseStart();
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
      expectRedirect("runaway", 10'h3FE);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      checkOutput("runaway_top_pc", 32'(pc), 32'h3FF);
      checkOutput("runaway_top_fv", 32'(fetch_valid), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      checkOutput("runaway_done", 32'(done), 32'd1);
      checkOutput("runaway_pc", 32'(pc), 32'h3FF);
      checkOutput("runaway_fv", 32'(fetch_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      checkOutput("runaway_pc_hold", 32'(pc), 32'h3FF);
      pulseStart();
      checkOutput("final_restart_pc", 32'(pc), 32'd0);
      checkOutput("final_restart_done", 32'(done), 32'd0);
      checkOutput("final_restart_fv", 32'(fetch_valid), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter and flag-state controller for the 9-bit CPU. It sits directly downstream of the ALU and consumes the ALU's `taken` and `carry_out` results. It sequences the PC through the instruction ROM, redirects it on taken branches via a small branch-target lookup table, and holds the carry flag that feeds back into the ALU's `carry_in`. It also provides the start/done handshake to the testbench/host.

## Interface
- `PC_W`, default 10: PC width; instruction ROM depth is 2^PC_W.
- `LUT_DEPTH`, default 16: number of branch-target entries; index width is $clog2(LUT_DEPTH).

Ports (name, direction, width, meaning):
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse to begin program execution from PC 0.
- `halt`  in  1  decoded halt instruction at the current PC.
- `branch_en`  in  1  decoded conditional-branch instruction at the current PC.
- `taken`  in  1  ALU branch condition for the current instruction.
- `lut_idx`  in  $clog2(LUT_DEPTH)  branch-target LUT index from the instruction.
- `carry_we`  in  1  the current instruction updates the carry flag.
- `carry_out`  in  1  ALU carry result.
- `lut_we`  in  1  LUT write strobe.
- `lut_waddr`  in  $clog2(LUT_DEPTH)  LUT write address.
- `lut_wdata`  in  PC_W  LUT write data (absolute target PC).
- `pc`  out  PC_W  current instruction address (registered).
- `fetch_valid`  out  1  the instruction at `pc` is being executed this cycle.
- `carry_q`  out  1  carry flag, fed to ALU `carry_in`.
- `done`  out  1  program finished.

## Operation
FSM states: IDLE, RUN, FLUSH, DONE.

- **IDLE:** `pc`=0, `fetch_valid`=0, `done`=0. LUT writes accepted. `start` → RUN; `pc`=0; `carry_q` cleared.
- **RUN:** `fetch_valid`=1. Priority each cycle is halt > taken branch > sequential.
  - `halt` → DONE; `pc` holds.
  - `branch_en & taken` → `pc` <= LUT[`lut_idx`]; state → FLUSH.
  - `branch_en & !taken`, or no branch → `pc` <= `pc`+1.
  - Runaway guard: if `pc` = 2^PC_W−1 and neither halt nor a taken branch occurs → DONE, `pc` holds (no wrap).
  - `start` is ignored in RUN.
- **FLUSH:** `fetch_valid`=0 for exactly one cycle; `pc` holds the target; all instruction inputs are ignored → RUN.
- **DONE:** `done`=1, `fetch_valid`=0, `pc` holds. LUT writes accepted. `start` → RUN with `pc`=0, `done`=0, `carry_q`=0.
- **Carry flag:** `carry_q` <= `carry_out` when `carry_we & fetch_valid`. This applies even in the same cycle as `halt` or a taken branch. It holds otherwise.
- **LUT:** `lut_we` is honoured only in IDLE or DONE and ignored in RUN and FLUSH. Because reads occur only in RUN, a read and a write never collide. An out-of-range `lut_waddr` or `lut_idx` (when LUT_DEPTH is not a power of 2) writes nothing and reads 0.
- **Reset** (any state, including mid-RUN or mid-FLUSH): state=IDLE, `pc`=0, `fetch_valid`=0, `carry_q`=0, `done`=0, all LUT entries=0.

## Timing
- All outputs are registered, or decoded from registered state only. There is no combinational path from inputs to outputs.
- `start` sampled high at edge t → RUN at t, with `pc`=0 and `fetch_valid`=1 in cycle t+1.
- Branch decision uses the `taken`/`branch_en` values presented during a `fetch_valid` cycle. The new `pc` is visible after the next edge. With flush enabled, the target executes 2 cycles after the branch: one bubble.
- `halt` sampled at edge t → `done`=1 from cycle t+1.
- `carry_q` updated at the edge ending the writing instruction, so it is visible to the next instruction.
- Reset is asynchronous: outputs reach reset values immediately on `reset` assertion, independent of `clk`.

## Configuration
- `PC_CTRL_FLUSH_EN` defined: the FLUSH state exists; a taken branch inserts one `fetch_valid`=0 bubble.
- `PC_CTRL_FLUSH_EN` undefined: the FLUSH state is removed. A taken branch goes RUN → RUN with `pc` <= target and `fetch_valid` remaining 1 (zero-bubble redirect).
- All other behaviour is identical in both builds.

## Test plan
- **Reset mid-run:** reset, then `start`; assert `reset` while `pc`=5 → `pc`=0, `fetch_valid`=0, `carry_q`=0, `done`=0 immediately. A later `start` restarts at `pc`=0.
- **Sequential run:** `start`, no branches, `halt` at `pc`=7 → `pc` steps 0..7, `done`=1 the cycle after, `pc` stays 7.
- **Branch taken vs. not taken:** load LUT[3]=0x120 in IDLE. At `pc`=4, `branch_en=1`, `lut_idx=3`:
  - `taken=1` → `pc`=0x120 next cycle; with flush, one bubble, then `fetch_valid`=1.
  - `taken=0` → `pc`=5.
- **Carry chain:** at `pc`=2, `carry_we=1`, `carry_out=1` → `carry_q`=1 during `pc`=3. Simultaneous `carry_we=1` with `halt` → `carry_q` updated and `done`=1.
- **LUT write gating:** `lut_we` during RUN at addr 3 with data 0x3FF → LUT[3] unchanged (a later branch via index 3 still reaches 0x120).
- **Runaway and restart:** LUT[0]=0x3FE, branch to it, no halt → `pc` 0x3FE, 0x3FF, then `done`=1 with `pc`=0x3FF. `start` in DONE → `pc`=0, `done`=0.
